// File: rtl/divide_issue_ctrl_64_64.sv
// Request-side issue controller for the 64/64 divide wrapper: ready/valid requests in,
// valid-only issue to the wrapper, credit-protected in-order tagged responses out.

module divide_issue_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Pointers carry one extra wrap bit so equal pointers always mean empty.
    assign empty = (wr_q == rd_q);
    assign head  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d  = wr_q + PW'(push);
        rd_d  = rd_q + PW'(pop && !empty);
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module divide_issue_ctrl_64_64 #(
    parameter int DATA_W       = 64,
    parameter int RES_W        = 8,
    parameter int TAG_W        = 4,
    parameter int DEPTH        = 16,
    parameter int DRAIN_CYCLES = 80
) (
    input  logic                       aclk,
    input  logic                       rst,
    input  logic                       s_req_valid,
    output logic                       s_req_ready,
    input  logic [DATA_W-1:0]          s_req_dividend,
    input  logic [DATA_W-1:0]          s_req_divisor,
    input  logic [TAG_W-1:0]           s_req_tag,
    output logic                       m_div_a_tvalid,
    output logic [DATA_W-1:0]          m_div_a_tdata,
    output logic                       m_div_b_tvalid,
    output logic [DATA_W-1:0]          m_div_b_tdata,
    input  logic                       s_div_tvalid,
    input  logic [RES_W-1:0]           s_div_tdata,
    output logic                       m_rsp_valid,
    input  logic                       m_rsp_ready,
    output logic [RES_W-1:0]           m_rsp_quotient,
    output logic [TAG_W-1:0]           m_rsp_tag,
    output logic                       m_rsp_divzero,
    output logic [$clog2(DEPTH):0]     credits,
    output logic                       err_spurious
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int TAG_EW  = TAG_W + 1;
    localparam int RSP_EW  = RES_W + TAG_W + 1;

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]    credits_q, credits_d;
    logic                issue_valid_q, issue_valid_d;
    logic [DATA_W-1:0]   div_a_q, div_a_d;
    logic [DATA_W-1:0]   div_b_q, div_b_d;
    logic                err_q, err_d;

    logic                run;
    logic                accept;
    logic                result_in;
    logic                capture;
    logic                rsp_hs;
    logic                tag_empty;
    logic                rsp_empty;
    logic [TAG_EW-1:0]   tag_head;
    logic [RSP_EW-1:0]   rsp_head;

    assign run         = (state_q == ST_RUN);
    assign s_req_ready = run && (credits_q != '0);
    assign accept      = s_req_valid && s_req_ready;
    assign result_in   = s_div_tvalid && run;
    assign capture     = result_in && !tag_empty;
    assign rsp_hs      = !rsp_empty && m_rsp_ready;

    divide_issue_ctrl_fifo #(
        .WIDTH (TAG_EW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (aclk),
        .rst       (rst),
        .push      (accept),
        .push_data ({s_req_tag, (s_req_divisor == '0)}),
        .pop       (capture),
        .empty     (tag_empty),
        .head      (tag_head)
    );

    // Credits guarantee this FIFO always has room when a wrapper result lands.
    divide_issue_ctrl_fifo #(
        .WIDTH (RSP_EW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk       (aclk),
        .rst       (rst),
        .push      (capture),
        .push_data ({s_div_tdata, tag_head}),
        .pop       (rsp_hs),
        .empty     (rsp_empty),
        .head      (rsp_head)
    );

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_DRAIN: begin
                if (drain_cnt_q <= DRAIN_W'(1)) begin
                    drain_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_DRAIN;
            end
        endcase
    end

    always_comb begin
        issue_valid_d = accept;
        div_a_d       = accept ? s_req_dividend : div_a_q;
        div_b_d       = accept ? s_req_divisor  : div_b_q;
        err_d         = err_q || (result_in && tag_empty);
        credits_d     = credits_q;
        case ({accept, rsp_hs})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q       <= ST_DRAIN;
            drain_cnt_q   <= DRAIN_W'(DRAIN_CYCLES);
            credits_q     <= CNT_W'(DEPTH);
            issue_valid_q <= 1'b0;
            div_a_q       <= '0;
            div_b_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            credits_q     <= credits_d;
            issue_valid_q <= issue_valid_d;
            div_a_q       <= div_a_d;
            div_b_q       <= div_b_d;
            err_q         <= err_d;
        end
    end

    assign m_div_a_tvalid = issue_valid_q;
    assign m_div_b_tvalid = issue_valid_q;
    assign m_div_a_tdata  = div_a_q;
    assign m_div_b_tdata  = div_b_q;

    // Head is masked while empty so the response bus reads zero after reset.
    assign m_rsp_valid    = !rsp_empty;
    assign m_rsp_quotient = rsp_empty ? '0 : rsp_head[RSP_EW-1 -: RES_W];
    assign m_rsp_tag      = rsp_empty ? '0 : rsp_head[TAG_W:1];
    assign m_rsp_divzero  = rsp_empty ? 1'b0 : rsp_head[0];
    assign credits        = credits_q;
    assign err_spurious   = err_q;
endmodule
